// File: rtl/cpu_bus_sequencer_pkg.sv
// Shared types and constants for the multi-cycle MIPS bus sequencer.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC  = 3'd1,
    S_MEM   = 3'd2,
    S_WB    = 3'd3,
    S_HALT  = 3'd4,
    S_ERROR = 3'd5
  } seq_state_t;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] HALT_PC      = 32'h0000_0000;

endpackage

// File: rtl/cpu_bus_sequencer_timeout.sv
// Saturating count of consecutive waitrequest cycles; flags the cycle that
// would bring the count to the limit.
module bus_timeout_counter #(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // next count: clear wins, otherwise count up until the limit
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_q < limit)) begin
      cnt_d = cnt_q + ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // independent of clear so the FSM can use it to pick its next state
  assign expired = inc && (cnt_q >= (limit - ONE));

endmodule

// File: rtl/cpu_bus_sequencer.sv
// Multi-cycle fetch/exec/mem/writeback sequencer driving the shared memory bus.
module cpu_bus_sequencer
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc,
  input  logic [31:0] data_addr,
  input  logic        mem_read_req,
  input  logic        mem_write_req,
  input  logic        hilo_stall,
  input  logic        halt_req,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] instr,
  output logic [31:0] load_data,
  output logic        pc_we,
  output logic        reg_we_en,
  output logic        active,
  output logic        bus_error
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  seq_state_t  state_q;
  seq_state_t  state_d;
  logic        run_q;
  logic [31:0] instr_q;
  logic [31:0] instr_d;
  logic [31:0] load_data_q;
  logic [31:0] load_data_d;
  logic        bus_wait;
  logic        cnt_clear;
  logic        timeout;

  assign bus_wait  = run_q && waitrequest && ((state_q == S_FETCH) || (state_q == S_MEM));
  assign cnt_clear = (state_d != state_q) || !waitrequest;

  bus_timeout_counter #(
    .CNT_W(CNT_W)
  ) u_timeout (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (cnt_clear),
    .inc    (bus_wait),
    .limit  (LIMIT),
    .expired(timeout)
  );

  // state, run qualifier and capture registers; run_q holds off the first
  // fetch until the first edge after reset release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_FETCH;
      run_q       <= 1'b0;
      instr_q     <= 32'h0000_0000;
      load_data_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      run_q       <= 1'b1;
      instr_q     <= instr_d;
      load_data_q <= load_data_d;
    end
  end

  // next-state and capture logic
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    load_data_d = load_data_q;
    if (!run_q) begin
      state_d = state_q;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (timeout) begin
            state_d = S_ERROR;
          end else if (!waitrequest) begin
            instr_d = readdata;
            state_d = S_EXEC;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_EXEC: begin
          if (hilo_stall) begin
            state_d = S_EXEC;
          end else if (mem_read_req || mem_write_req) begin
            state_d = S_MEM;
          end else begin
            state_d = S_WB;
          end
        end
        S_MEM: begin
          if (timeout) begin
            state_d = S_ERROR;
          end else if (!waitrequest) begin
            if (mem_read_req) begin
              load_data_d = readdata;
            end else begin
              load_data_d = load_data_q;
            end
            state_d = S_WB;
          end else begin
            state_d = S_MEM;
          end
        end
        S_WB: begin
          if (halt_req) begin
            state_d = S_HALT;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_HALT:  state_d = S_HALT;
        S_ERROR: state_d = S_ERROR;
        default: state_d = S_ERROR;
      endcase
    end
  end

  // output decode from the state register; mem_read_req wins on illegal decode
  always_comb begin
    address   = pc;
    read      = 1'b0;
    write     = 1'b0;
    pc_we     = 1'b0;
    reg_we_en = 1'b0;
    active    = 1'b0;
    bus_error = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (run_q) begin
          read   = 1'b1;
          active = 1'b1;
        end else begin
          read   = 1'b0;
          active = 1'b0;
        end
      end
      S_EXEC: begin
        active = 1'b1;
      end
      S_MEM: begin
        address = data_addr;
        read    = mem_read_req;
        write   = mem_write_req && !mem_read_req;
        active  = 1'b1;
      end
      S_WB: begin
        pc_we     = 1'b1;
        reg_we_en = 1'b1;
        active    = 1'b1;
      end
      S_HALT: begin
        active = 1'b0;
      end
      S_ERROR: begin
        bus_error = 1'b1;
      end
      default: begin
        bus_error = 1'b1;
      end
    endcase
  end

  assign instr     = instr_q;
  assign load_data = load_data_q;

endmodule

// File: tb/tb_cpu_bus_sequencer.sv
// Randomized instruction-level bench for cpu_bus_sequencer with an expected bus trace per instruction.
module tb_cpu_bus_sequencer;
  import cpu_pkg::*;

  localparam int T = 1024;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc;
  logic [31:0] data_addr;
  logic        mem_read_req;
  logic        mem_write_req;
  logic        hilo_stall;
  logic        halt_req;
  logic        waitrequest;
  logic [31:0] readdata;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] instr;
  logic [31:0] load_data;
  logic        pc_we;
  logic        reg_we_en;
  logic        active;
  logic        bus_error;

  int          total = 0;
  int          bad = 0;
  logic [31:0] model_instr;
  logic [31:0] model_load;

  always #5 clk = ~clk;

  cpu_bus_sequencer #(
    .TIMEOUT_CYCLES(T),
    .CNT_W(11)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pc           (pc),
    .data_addr    (data_addr),
    .mem_read_req (mem_read_req),
    .mem_write_req(mem_write_req),
    .hilo_stall   (hilo_stall),
    .halt_req     (halt_req),
    .waitrequest  (waitrequest),
    .readdata     (readdata),
    .address      (address),
    .read         (read),
    .write        (write),
    .instr        (instr),
    .load_data    (load_data),
    .pc_we        (pc_we),
    .reg_we_en    (reg_we_en),
    .active       (active),
    .bus_error    (bus_error)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Check one cycle's outputs at the falling edge, then advance past the next rising edge.
  task automatic expect_cycle(input string ph, input logic e_rd, input logic e_wr,
                              input logic [31:0] e_addr, input logic e_we,
                              input logic e_act, input logic e_err);
    @(negedge clk);
    check_val({ph, ".read"}, {31'b0, read}, {31'b0, e_rd});
    check_val({ph, ".write"}, {31'b0, write}, {31'b0, e_wr});
    check_val({ph, ".pc_we"}, {31'b0, pc_we}, {31'b0, e_we});
    check_val({ph, ".reg_we_en"}, {31'b0, reg_we_en}, {31'b0, e_we});
    check_val({ph, ".active"}, {31'b0, active}, {31'b0, e_act});
    check_val({ph, ".bus_error"}, {31'b0, bus_error}, {31'b0, e_err});
    if (e_rd || e_wr) check_val({ph, ".address"}, address, e_addr);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    waitrequest = 1'b0; hilo_stall = 1'b0; halt_req = 1'b0;
    mem_read_req = 1'b0; mem_write_req = 1'b0;
    readdata = $urandom; data_addr = $urandom; pc = RESET_VECTOR;
    model_instr = 32'h0; model_load = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst.read", {31'b0, read}, 32'h0);
    check_val("rst.write", {31'b0, write}, 32'h0);
    check_val("rst.pc_we", {31'b0, pc_we}, 32'h0);
    check_val("rst.active", {31'b0, active}, 32'h0);
    check_val("rst.bus_error", {31'b0, bus_error}, 32'h0);
    check_val("rst.instr", instr, 32'h0);
    check_val("rst.load_data", load_data, 32'h0);
    reset_n = 1'b1;
    expect_cycle("prerun", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // kind: 0 alu/branch, 1 load, 2 store, 3 illegal both-requests (behaves as load)
  task automatic run_instr(input int kind, input int fw, input int st, input int mw,
                           input logic halt, input logic [31:0] pcv);
    logic [31:0] word;
    logic [31:0] daddr;
    logic [31:0] ldv;
    logic        is_rd;
    logic        is_wr;
    word = $urandom; daddr = $urandom; ldv = $urandom;
    is_rd = (kind == 1) || (kind == 3);
    is_wr = (kind == 2);
    pc = pcv; data_addr = daddr; halt_req = 1'b0; hilo_stall = 1'b0;
    mem_read_req = is_rd;
    mem_write_req = (kind == 2) || (kind == 3);
    for (int k = 0; k < fw; k++) begin
      waitrequest = 1'b1; readdata = $urandom;
      expect_cycle("fetch", 1'b1, 1'b0, pcv, 1'b0, 1'b1, 1'b0);
    end
    waitrequest = 1'b0; readdata = word;
    expect_cycle("fetch", 1'b1, 1'b0, pcv, 1'b0, 1'b1, 1'b0);
    model_instr = word;
    for (int k = 0; k <= st; k++) begin
      hilo_stall = (k < st); waitrequest = 1'($urandom_range(0, 1)); readdata = $urandom;
      expect_cycle("exec", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    end
    hilo_stall = 1'b0;
    if (kind != 0) begin
      for (int k = 0; k < mw; k++) begin
        waitrequest = 1'b1; readdata = $urandom;
        expect_cycle("mem", is_rd, is_wr, daddr, 1'b0, 1'b1, 1'b0);
      end
      waitrequest = 1'b0; readdata = ldv;
      expect_cycle("mem", is_rd, is_wr, daddr, 1'b0, 1'b1, 1'b0);
      if (is_rd) model_load = ldv;
    end
    waitrequest = 1'($urandom_range(0, 1)); halt_req = halt; readdata = $urandom;
    expect_cycle("wb", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    halt_req = 1'b0;
    check_val("instr", instr, model_instr);
    check_val("load_data", load_data, model_load);
  endtask

  initial begin
    do_reset();
    run_instr(0, 0, 0, 0, 1'b0, RESET_VECTOR);
    run_instr(1, 0, 0, 3, 1'b0, RESET_VECTOR + 32'd4);
    run_instr(2, 0, 0, 0, 1'b0, RESET_VECTOR + 32'd8);
    run_instr(0, 0, 5, 0, 1'b0, RESET_VECTOR + 32'd12);
    run_instr(3, 1, 0, 1, 1'b0, RESET_VECTOR + 32'd16);
    for (int i = 0; i < 40; i++) begin
      run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, $urandom);
    end
    run_instr(0, 0, 0, 0, 1'b1, 32'h0000_0040);
    for (int i = 0; i < 4; i++) begin
      waitrequest = 1'($urandom_range(0, 1));
      expect_cycle("halt", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    end

    // waitrequest stuck during fetch
    do_reset();
    waitrequest = 1'b1;
    for (int i = 0; i < T; i++) begin
      readdata = $urandom;
      expect_cycle("stuck", 1'b1, 1'b0, RESET_VECTOR, 1'b0, 1'b1, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      waitrequest = 1'($urandom_range(0, 1));
      expect_cycle("error", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    end

    // reset pulse while a store is waiting in MEM
    do_reset();
    data_addr = 32'h0000_1230; mem_read_req = 1'b0; mem_write_req = 1'b1;
    waitrequest = 1'b0; readdata = 32'h2222_0001;
    expect_cycle("fetch", 1'b1, 1'b0, RESET_VECTOR, 1'b0, 1'b1, 1'b0);
    expect_cycle("exec", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    waitrequest = 1'b1;
    expect_cycle("mem", 1'b0, 1'b1, 32'h0000_1230, 1'b0, 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("midrst.write", {31'b0, write}, 32'h0);
    check_val("midrst.read", {31'b0, read}, 32'h0);
    check_val("midrst.active", {31'b0, active}, 32'h0);
    check_val("midrst.instr", instr, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    waitrequest = 1'b0; mem_write_req = 1'b0;
    expect_cycle("prerun", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    model_instr = 32'h0;
    run_instr(0, 0, 0, 0, 1'b0, RESET_VECTOR);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
